// File: rtl/seg_display_ctrl.sv
// Eight-digit multiplexed 7-segment driver for the vending machine front panel.
// Shows state-dependent text plus three money fields converted to BCD by a shared serial converter.
module seg_display_ctrl #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [5:0] state_in,
    input  logic [7:0] input_money,
    input  logic [7:0] need_money,
    input  logic [7:0] change_money,
    output logic [7:0] Bit_select,
    output logic [7:0] Seg_select
);

    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [5:0] ST_IDLE   = 6'b000001;
    localparam logic [5:0] ST_GOODS1 = 6'b000010;
    localparam logic [5:0] ST_GOODS2 = 6'b000100;
    localparam logic [5:0] ST_PAY    = 6'b001000;
    localparam logic [5:0] ST_CHANGE = 6'b010000;
    localparam logic [5:0] ST_TEMP   = 6'b100000;

    localparam logic [7:0] G_DASH  = 8'hBF;
    localparam logic [7:0] G_BLANK = 8'hFF;
    localparam logic [7:0] G_C     = 8'hC6;
    localparam logic [7:0] G_G     = 8'hC2;
    localparam logic [7:0] G_P     = 8'h8C;

    typedef enum logic {CV_LOAD, CV_SHIFT} cv_state_e;

    function automatic logic [7:0] digit_glyph(input logic [3:0] v);
        case (v)
            4'd0:    digit_glyph = 8'hC0;
            4'd1:    digit_glyph = 8'hF9;
            4'd2:    digit_glyph = 8'hA4;
            4'd3:    digit_glyph = 8'hB0;
            4'd4:    digit_glyph = 8'h99;
            4'd5:    digit_glyph = 8'h92;
            4'd6:    digit_glyph = 8'h82;
            4'd7:    digit_glyph = 8'hF8;
            4'd8:    digit_glyph = 8'h80;
            4'd9:    digit_glyph = 8'h90;
            default: digit_glyph = G_BLANK;
        endcase
    endfunction

    // Leading-zero suppression: pos 2 = hundreds, 1 = tens, 0 = units.
    function automatic logic [7:0] field_glyph(input logic [11:0] bcd, input logic [1:0] pos);
        case (pos)
            2'd2:    field_glyph = (bcd[11:8] == 4'd0) ? G_BLANK : digit_glyph(bcd[11:8]);
            2'd1:    field_glyph = (bcd[11:4] == 8'd0) ? G_BLANK : digit_glyph(bcd[7:4]);
            default: field_glyph = digit_glyph(bcd[3:0]);
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] nib);
        add3 = (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    logic [1:0]         rst_sync_q, rst_sync_d;
    logic               rst_core_n;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    cv_state_e          cv_state_q, cv_state_d;
    logic [1:0]         cv_sel_q, cv_sel_d;
    logic [2:0]         cv_cnt_q, cv_cnt_d;
    logic [7:0]         op_q, op_d;
    logic [19:0]        work_q, work_d;
    logic [11:0]        bcd_in_q, bcd_in_d, bcd_need_q, bcd_need_d, bcd_chg_q, bcd_chg_d;
    logic [7:0]         bit_sel_q, bit_sel_d, seg_sel_q, seg_sel_d;
    logic [7:0]         operand_c;
    logic [11:0]        adj_c;
    logic [19:0]        shifted_c;

    // Release is synchronized; assertion stays asynchronous through the clear.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_core_n = rst_sync_q[1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rst_sync_q <= '0;
        else            rst_sync_q <= rst_sync_d;
    end

    always_comb begin
        case (cv_sel_q)
            2'd1:    operand_c = need_money;
            2'd2:    operand_c = change_money;
            default: operand_c = input_money;
        endcase
        adj_c     = {add3(work_q[19:16]), add3(work_q[15:12]), add3(work_q[11:8])};
        shifted_c = {adj_c, work_q[7:0]} << 1;
    end

    // Scan prescaler, blink timer and serial double-dabble converter.
    always_comb begin
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_d     = phase_q;
        cv_state_d  = cv_state_q;
        cv_sel_d    = cv_sel_q;
        cv_cnt_d    = cv_cnt_q;
        op_d        = op_q;
        work_d      = work_q;
        bcd_in_d    = bcd_in_q;
        bcd_need_d  = bcd_need_q;
        bcd_chg_d   = bcd_chg_q;

        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end

        if (state_in != ST_TEMP) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        case (cv_state_q)
            CV_LOAD: begin
                op_d       = operand_c;
                work_d     = {12'd0, operand_c};
                cv_cnt_d   = 3'd0;
                cv_state_d = CV_SHIFT;
            end
            default: begin
                // A changed operand restarts its own conversion rather than waiting a full round.
                if (operand_c != op_q) begin
                    cv_state_d = CV_LOAD;
                end else begin
                    work_d   = shifted_c;
                    cv_cnt_d = cv_cnt_q + 3'd1;
                    if (cv_cnt_q == 3'd7) begin
                        case (cv_sel_q)
                            2'd1:    bcd_need_d = shifted_c[19:8];
                            2'd2:    bcd_chg_d  = shifted_c[19:8];
                            default: bcd_in_d   = shifted_c[19:8];
                        endcase
                        cv_sel_d   = (cv_sel_q == 2'd2) ? 2'd0 : cv_sel_q + 2'd1;
                        cv_state_d = CV_LOAD;
                    end
                end
            end
        endcase
    end

    // Glyph is chosen for the next index so enable and segments change together.
    always_comb begin
        bit_sel_d = ~(8'd1 << idx_d);
        seg_sel_d = G_BLANK;
        case (state_in)
            ST_IDLE:   seg_sel_d = G_DASH;
            ST_GOODS1: if (idx_d == 3'd7) seg_sel_d = G_G;
                       else if (idx_d == 3'd6) seg_sel_d = digit_glyph(4'd1);
            ST_GOODS2: if (idx_d == 3'd7) seg_sel_d = G_G;
                       else if (idx_d == 3'd6) seg_sel_d = digit_glyph(4'd2);
            ST_PAY:    if (idx_d == 3'd7) seg_sel_d = G_P;
                       else if (idx_d >= 3'd4) seg_sel_d = field_glyph(bcd_need_q, 2'(idx_d - 3'd4));
                       else if (idx_d <= 3'd2) seg_sel_d = field_glyph(bcd_in_q, idx_d[1:0]);
            ST_CHANGE: if (idx_d == 3'd7) seg_sel_d = G_C;
                       else if (idx_d <= 3'd2) seg_sel_d = field_glyph(bcd_chg_q, idx_d[1:0]);
            ST_TEMP:   if (idx_d <= 3'd2 && !phase_q) seg_sel_d = field_glyph(bcd_in_q, idx_d[1:0]);
            default:   seg_sel_d = G_BLANK;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            scan_cnt_q  <= '0;
            idx_q       <= 3'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            cv_state_q  <= CV_LOAD;
            cv_sel_q    <= 2'd0;
            cv_cnt_q    <= 3'd0;
            op_q        <= 8'd0;
            work_q      <= 20'd0;
            bcd_in_q    <= 12'd0;
            bcd_need_q  <= 12'd0;
            bcd_chg_q   <= 12'd0;
            bit_sel_q   <= 8'hFE;
            seg_sel_q   <= 8'hFF;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            cv_state_q  <= cv_state_d;
            cv_sel_q    <= cv_sel_d;
            cv_cnt_q    <= cv_cnt_d;
            op_q        <= op_d;
            work_q      <= work_d;
            bcd_in_q    <= bcd_in_d;
            bcd_need_q  <= bcd_need_d;
            bcd_chg_q   <= bcd_chg_d;
            bit_sel_q   <= bit_sel_d;
            seg_sel_q   <= seg_sel_d;
        end
    end

    assign Bit_select = bit_sel_q;
    assign Seg_select = seg_sel_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: per-cycle comparison against a text-level display model,
// plus hand-computed glyph checks for the scan order, money fields, blink and reset.
module tb_seg_display_ctrl;

    localparam int SCAN  = 4;
    localparam int BLINK = 8;
    localparam int SYNC  = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [5:0] state_in = 6'b000001;
    logic [7:0] input_money = 8'd0;
    logic [7:0] need_money = 8'd0;
    logic [7:0] change_money = 8'd0;
    logic [7:0] Bit_select, Seg_select;

    int cyc = 0;
    int rel_cyc = 0;
    int quiet_until = 1000000;
    int temp_cyc = 0;
    int checks = 0;
    int passes = 0;
    bit started = 1'b0;

    seg_display_ctrl #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .state_in(state_in),
        .input_money(input_money), .need_money(need_money), .change_money(change_money),
        .Bit_select(Bit_select), .Seg_select(Seg_select)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [7:0] glyph_of(input byte c);
        case (c)
            "0": return 8'hC0;  "1": return 8'hF9;  "2": return 8'hA4;  "3": return 8'hB0;
            "4": return 8'h99;  "5": return 8'h92;  "6": return 8'h82;  "7": return 8'hF8;
            "8": return 8'h80;  "9": return 8'h90;  "-": return 8'hBF;  "C": return 8'hC6;
            "G": return 8'hC2;  "P": return 8'h8C;  default: return 8'hFF;
        endcase
    endfunction

    // One character of a 3-digit money field with leading zeros shown as spaces.
    function automatic byte field_char(input int v, input int pos);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        if (pos == 2) return (h == 0) ? " " : byte'(48 + h);
        if (pos == 1) return (h == 0 && t == 0) ? " " : byte'(48 + t);
        return byte'(48 + u);
    endfunction

    function automatic logic [7:0] model_seg(input int d, input logic [5:0] st,
                                             input int inp, input int need, input int chg, input int ph);
        byte c;
        c = " ";
        case (st)
            6'b000001: c = "-";
            6'b000010: c = (d == 7) ? "G" : (d == 6) ? "1" : " ";
            6'b000100: c = (d == 7) ? "G" : (d == 6) ? "2" : " ";
            6'b001000: if (d == 7) c = "P";
                       else if (d >= 4) c = field_char(need, d - 4);
                       else if (d <= 2) c = field_char(inp, d);
            6'b010000: if (d == 7) c = "C";
                       else if (d <= 2) c = field_char(chg, d);
            6'b100000: if (d <= 2 && ph == 0) c = field_char(inp, d);
            default:   c = " ";
        endcase
        return glyph_of(c);
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge sys_clk) begin
        int m, idx, ph;
        logic [7:0] eb;
        if (started && sys_rst_n) begin
            m = cyc - rel_cyc - SYNC;
            if (m < 1) begin
                chk("reset_bit", Bit_select, 8'hFE);
                chk("reset_seg", Seg_select, 8'hFF);
            end else begin
                idx = (m / SCAN) % 8;
                eb = 8'hFF;
                eb[idx] = 1'b0;
                chk("scan_bit", Bit_select, eb);
                if (cyc >= quiet_until) begin
                    ph = ((cyc - temp_cyc - 1) / BLINK) % 2;
                    chk("model_seg", Seg_select,
                        model_seg(idx, state_in, int'(input_money), int'(need_money), int'(change_money), ph));
                end
            end
        end
    end

    // Called just after a negedge: applies new inputs and marks the settling window.
    task automatic drive(input logic [5:0] st, input logic [7:0] i, input logic [7:0] n, input logic [7:0] c);
        #1;
        if (i != input_money || n != need_money || c != change_money) quiet_until = cyc + 32;
        else if (st != state_in && quiet_until < cyc + 1) quiet_until = cyc + 1;
        if (st == 6'b100000 && state_in != 6'b100000) temp_cyc = cyc;
        state_in = st;
        input_money = i;
        need_money = n;
        change_money = c;
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        #1;
        rel_cyc = cyc;
        quiet_until = cyc + 32;
        sys_rst_n = 1'b1;
        started = 1'b1;
    endtask

    task automatic wait_n(input int n);
        while (cyc - rel_cyc < n) @(negedge sys_clk);
    endtask

    // Returns on the first negedge where Bit_select newly equals pat.
    task automatic wait_bit(input logic [7:0] pat);
        int guard;
        guard = 0;
        do begin @(negedge sys_clk); guard++; end while (Bit_select == pat && guard < 100);
        do begin @(negedge sys_clk); guard++; end while (Bit_select != pat && guard < 100);
        if (guard >= 100) chk("wait_bit_timeout", Bit_select, pat);
    endtask

    task automatic check_digit(input string name, input int d, input logic [7:0] exp);
        logic [7:0] pat;
        int guard;
        pat = 8'hFF;
        pat[d] = 1'b0;
        guard = 0;
        do begin @(negedge sys_clk); guard++; end while (Bit_select != pat && guard < 40);
        if (guard >= 40) chk({name, "_timeout"}, Bit_select, pat);
        else chk(name, Seg_select, exp);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("por_bit", Bit_select, 8'hFE);
        chk("por_seg", Seg_select, 8'hFF);

        release_reset();
        wait_n(3);  chk("idle_n3_bit", Bit_select, 8'hFE); chk("idle_n3_seg", Seg_select, 8'hBF);
        wait_n(5);  chk("idle_n5_bit", Bit_select, 8'hFE);
        wait_n(6);  chk("idle_n6_bit", Bit_select, 8'hFD); chk("idle_n6_seg", Seg_select, 8'hBF);
        wait_n(10); chk("idle_n10_bit", Bit_select, 8'hFB);
        wait_n(30); chk("idle_n30_bit", Bit_select, 8'h7F); chk("idle_n30_seg", Seg_select, 8'hBF);
        wait_n(34); chk("idle_n34_bit", Bit_select, 8'hFE);

        @(negedge sys_clk); drive(6'b001000, 8'd120, 8'd15, 8'd0);
        repeat (30) @(negedge sys_clk);
        check_digit("pay_d7", 7, 8'h8C); check_digit("pay_d6", 6, 8'hFF);
        check_digit("pay_d5", 5, 8'hF9); check_digit("pay_d4", 4, 8'h92);
        check_digit("pay_d3", 3, 8'hFF); check_digit("pay_d2", 2, 8'hF9);
        check_digit("pay_d1", 1, 8'hA4); check_digit("pay_d0", 0, 8'hC0);

        @(negedge sys_clk); drive(6'b010000, 8'd120, 8'd15, 8'd0);
        repeat (30) @(negedge sys_clk);
        check_digit("chg0_d7", 7, 8'hC6); check_digit("chg0_d2", 2, 8'hFF);
        check_digit("chg0_d1", 1, 8'hFF); check_digit("chg0_d0", 0, 8'hC0);
        @(negedge sys_clk); drive(6'b010000, 8'd120, 8'd15, 8'd205);
        repeat (30) @(negedge sys_clk);
        check_digit("chg205_d2", 2, 8'hA4); check_digit("chg205_d1", 1, 8'hC0);
        check_digit("chg205_d0", 0, 8'h92);

        @(negedge sys_clk); drive(6'b000010, 8'd7, 8'd15, 8'd205);
        repeat (30) @(negedge sys_clk);
        check_digit("g1_d7", 7, 8'hC2); check_digit("g1_d6", 6, 8'hF9); check_digit("g1_d0", 0, 8'hFF);
        @(negedge sys_clk); drive(6'b000100, 8'd7, 8'd15, 8'd205);
        check_digit("g2_d6", 6, 8'hA4);

        // TEMP entered with index 7 on screen: digit 0 comes up 4 edges later, still visible phase.
        wait_bit(8'h7F); drive(6'b100000, 8'd7, 8'd15, 8'd205);
        repeat (4) @(negedge sys_clk);
        chk("temp_on_bit", Bit_select, 8'hFE); chk("temp_on_seg", Seg_select, 8'hF8);
        repeat (3) @(negedge sys_clk);
        chk("temp_on_late_seg", Seg_select, 8'hF8);

        // Entered at index 5: digit 0 appears 12 edges later, inside the blanked half-period.
        @(negedge sys_clk); drive(6'b000001, 8'd7, 8'd15, 8'd205);
        wait_bit(8'hDF); drive(6'b100000, 8'd7, 8'd15, 8'd205);
        repeat (12) @(negedge sys_clk);
        chk("temp_off_bit", Bit_select, 8'hFE); chk("temp_off_seg", Seg_select, 8'hFF);

        @(negedge sys_clk); drive(6'b000001, 8'd7, 8'd15, 8'd205);
        repeat (20) @(negedge sys_clk);
        wait_bit(8'h7F); drive(6'b100000, 8'd7, 8'd15, 8'd205);
        repeat (4) @(negedge sys_clk);
        chk("temp_reentry_seg", Seg_select, 8'hF8);
        repeat (40) @(negedge sys_clk);

        @(negedge sys_clk); drive(6'b001100, 8'd7, 8'd15, 8'd205);
        check_digit("bad_d7", 7, 8'hFF); check_digit("bad_d6", 6, 8'hFF); check_digit("bad_d0", 0, 8'hFF);

        @(negedge sys_clk); drive(6'b000001, 8'd7, 8'd15, 8'd205);
        wait_bit(8'hDF);
        @(posedge sys_clk); #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst_bit", Bit_select, 8'hFE); chk("async_rst_seg", Seg_select, 8'hFF);
        repeat (3) @(negedge sys_clk);
        chk("held_rst_bit", Bit_select, 8'hFE);
        release_reset();
        wait_n(3); chk("rerel_n3_bit", Bit_select, 8'hFE); chk("rerel_n3_seg", Seg_select, 8'hBF);
        wait_n(6); chk("rerel_n6_bit", Bit_select, 8'hFD);
        repeat (40) @(negedge sys_clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning sys_clk cycles each digit stays enabled (legal range 2..2^20).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, meaning sys_clk cycles per blink half-period (legal range 2..2^26).
REQ-003 SHALL have port sys_clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port state_in, input, 6, one-hot vending state: IDLE=000001, GOODS_one=000010, GOODS_two=000100, PAYMENT=001000, CHANGE=010000, TEMP=100000.
REQ-006 SHALL have port input_money, input, 8, unsigned binary inserted total.
REQ-007 SHALL have port need_money, input, 8, unsigned binary price.
REQ-008 SHALL have port change_money, input, 8, unsigned binary remaining change.
REQ-009 SHALL have port Bit_select, output, 8, registered active-low digit enables; bit 7 is the leftmost digit.
REQ-010 SHALL have port Seg_select, output, 8, registered active-low segments, order {dp,g,f,e,d,c,b,a}.

Function
REQ-011 Scan: SHALL use a prescaler counting 0..SCAN_DIV-1; at terminal count it wraps to 0 and the 3-bit digit index increments, wrapping 7->0.
REQ-012 SHALL drive Bit_select = ~(1<<index) with exactly one bit low at all times after reset.
REQ-013 SHALL register Bit_select and Seg_select on the same edge, so glyph and enable always match; no cycle may pair the new index with the old glyph.
REQ-014 BCD conversion: SHALL use a sequential shift-add-3 converter serving input_money, need_money and change_money round-robin.
REQ-015 Each conversion SHALL take 9 cycles (1 load + 8 shifts) and write a 3-digit BCD result register; any operand change SHALL be visible in its BCD register within 27 cycles.
REQ-016 Glyphs (hex, active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 '-'=BF blank=FF C=C6 G=C2 P=8C; dp SHALL always be off.
REQ-017 Number field (3 digits): hundreds SHALL be blank if 0; tens SHALL be blank if hundreds and tens are both 0; units SHALL always be shown (value 0 shows "0").
REQ-018 IDLE: all 8 digits SHALL show '-'.
REQ-019 GOODS_one: digit7='G', digit6='1', rest blank. GOODS_two: digit7='G', digit6='2', rest blank.
REQ-020 PAYMENT: digit7='P', digits6..4=need_money field, digit3 blank, digits2..0=input_money field.
REQ-021 CHANGE: digit7='C', digits6..3 blank, digits2..0=change_money field.
REQ-022 TEMP: digits2..0=input_money field, others blank; the field SHALL blink (blank when blink phase=1).
REQ-023 Blink: counter counts 0..BLINK_DIV-1 and toggles the phase at terminal count; counter and phase SHALL clear to 0 on any cycle where state_in is not TEMP, so TEMP entry starts visible.
REQ-024 A non-one-hot state_in (zero or multiple bits) SHALL blank all digits.
REQ-025 Display content SHALL follow state_in with at most 1 cycle latency plus the conversion latency of REQ-015.

Reset
REQ-026 While sys_rst_n=0: prescaler=0, index=0, Bit_select=8'hFE, Seg_select=8'hFF, blink counter=0, phase=0, BCD registers=0, converter idle at operand input_money.
REQ-027 Deassertion SHALL be synchronized internally; the first scan terminal count SHALL occur SCAN_DIV cycles after the first active edge.
REQ-028 Reset mid-conversion SHALL abort the conversion and discard partial results.

Verification (SCAN_DIV=4, BLINK_DIV=8)
REQ-029 Reset released, IDLE -> Bit_select cycles FE,FD,FB,...,7F,FE every 4 clocks; Seg_select=BF on every digit.
REQ-030 PAYMENT, need=15, input=120, after 30 cycles -> digit7=8C, digit6=FF, digit5=F9, digit4=92, digit3=FF, digit2=F9, digit1=A4, digit0=C0.
REQ-031 CHANGE, change=0 -> digits2..0 = FF,FF,C0; change set to 205 -> within 27 cycles digits2..0 = A4,C0,92.
REQ-032 TEMP, input=7 -> digit0 shows F8 for 8 cycles, then FF for 8 cycles, repeating; leaving TEMP and re-entering restarts with F8.
REQ-033 state_in=001100 -> all digits FF; reset asserted mid-scan at index 5 -> Bit_select=FE and Seg_select=FF immediately (asynchronous).
